// File: rtl/clk_otp_100k_monitor_if.sv
// Status/stimulus bundle for the 100 kHz OTP clock monitor.
// master: drives clk_otp_in, mode; slave (monitor): drives lock/fault/measure.
interface clk_otp_100k_monitor_if #(
    parameter int CNT_W = 12
);
    logic             clk_otp_in;
    logic [1:0]       mode;
    logic             locked;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] last_half_period;
    logic             half_valid;

    modport master (
        output clk_otp_in, mode,
        input  locked, fault, fault_code,
        input  last_half_period, half_valid
    );

    modport slave (
        input  clk_otp_in, mode,
        output locked, fault, fault_code,
        output last_half_period, half_valid
    );
endinterface

// File: rtl/clk_otp_100k_monitor.sv
// Consumer-side checker for the divided 100 kHz OTP clock. Measures every
// half-period of clk_otp_in in clk_osc_50MHz cycles, declares lock after
// LOCK_CNT in-window half-periods, raises a sticky fault on short/long/stall.
// Ports: clk_osc_50MHz, soft_reset (sync, active-high), mon (slave modport:
//   clk_otp_in, mode in; locked, fault, fault_code, last_half_period,
//   half_valid out). Optional macro CLK_OTP_MON_IRQ_EN adds irq_clr / irq.
module clk_otp_100k_monitor #(
    parameter int HALF_PERIOD = 250,
    parameter int TOL         = 5,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 12
) (
    input  logic                         clk_osc_50MHz,
    input  logic                         soft_reset,
    clk_otp_100k_monitor_if.slave        mon
`ifdef CLK_OTP_MON_IRQ_EN
    ,
    input  logic                         irq_clr,
    output logic                         irq
`endif
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(HALF_PERIOD - TOL);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(HALF_PERIOD + TOL);
    localparam logic [CNT_W-1:0] SYNC_TO = CNT_W'(2 * (HALF_PERIOD + TOL));
    localparam logic [GW-1:0]    LOCK_N  = GW'(LOCK_CNT);

    typedef enum logic [2:0] {
        IDLE, SYNC, TRACK, LOCKED, FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]          good_q, good_d;
    logic                   locked_q, locked_d;
    logic                   fault_q, fault_d;
    logic [1:0]             code_q, code_d;
    logic [CNT_W-1:0]       last_q, last_d;
    logic                   hv_q, hv_d;
`ifdef CLK_OTP_MON_IRQ_EN
    logic                   irq_q, irq_d;
`endif

    logic             edge_w;
    logic             cnt_sat;
    logic [CNT_W-1:0] m;
    logic [GW-1:0]    good_inc;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], mon.clk_otp_in};
        prev_d   = sync_q[SYNC_STAGES-1];
        edge_w   = sync_q[SYNC_STAGES-1] ^ prev_q;
        cnt_sat  = &cnt_q;
        // Measured length includes the edge cycle itself; saturate too.
        m        = cnt_sat ? cnt_q : cnt_q + 1'b1;
        good_inc = good_q + 1'b1;

        cnt_d   = edge_w ? '0 : m;
        state_d = state_q;
        good_d  = good_q;
        hv_d    = 1'b0;
        last_d  = last_q;
        code_d  = code_q;

        unique case (state_q)
            IDLE: begin
                state_d = SYNC;
                cnt_d   = '0;
                good_d  = '0;
            end
            SYNC: begin
                // First edge only aligns us; its length is meaningless.
                if (edge_w) begin
                    state_d = TRACK;
                    good_d  = '0;
                end else if (cnt_q >= SYNC_TO) begin
                    state_d = FAULT;
                    code_d  = 2'b10;
                end
            end
            TRACK, LOCKED: begin
                // An edge coinciding with the timeout is measured, not timed out.
                if (edge_w) begin
                    hv_d   = 1'b1;
                    last_d = m;
                    if (m < WIN_LO) begin
                        state_d = FAULT;
                        code_d  = 2'b01;
                    end else if (m > WIN_HI) begin
                        state_d = FAULT;
                        code_d  = 2'b10;
                    end else if (state_q == TRACK) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (cnt_q >= WIN_HI) begin
                    state_d = FAULT;
                    code_d  = 2'b10;
                end
            end
            FAULT: begin
                if (edge_w) begin
                    hv_d   = 1'b1;
                    last_d = m;
                end
            end
            default: state_d = IDLE;
        endcase

        // Monitor off: clear everything except the synchronizer.
        if (mon.mode == 2'b00) begin
            state_d = IDLE;
            cnt_d   = '0;
            good_d  = '0;
            hv_d    = 1'b0;
            last_d  = '0;
            code_d  = 2'b00;
        end

        locked_d = (state_d == LOCKED);
        fault_d  = (state_d == FAULT);

`ifdef CLK_OTP_MON_IRQ_EN
        // Set on fault entry beats a same-cycle clear.
        if (state_d == FAULT && state_q != FAULT) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
`endif
    end

    always_ff @(posedge clk_osc_50MHz) begin
        if (soft_reset) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= 2'b00;
            last_q   <= '0;
            hv_q     <= 1'b0;
`ifdef CLK_OTP_MON_IRQ_EN
            irq_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            last_q   <= last_d;
            hv_q     <= hv_d;
`ifdef CLK_OTP_MON_IRQ_EN
            irq_q    <= irq_d;
`endif
        end
    end

    assign mon.locked           = locked_q;
    assign mon.fault            = fault_q;
    assign mon.fault_code       = code_q;
    assign mon.last_half_period = last_q;
    assign mon.half_valid       = hv_q;
`ifdef CLK_OTP_MON_IRQ_EN
    assign irq = irq_q;
`endif
endmodule
